// File: rtl/coh_req_arbiter.sv
// Round-robin coherence request arbiter with per-line serialisation.
// A line stays blocked from allocation until its completion returns.
module coh_req_arbiter #(
    parameter int CORES      = 4,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int MAX_OUTST  = 2,
    parameter int SRC_W      = $clog2(CORES)
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [CORES-1:0]               req_valid,
    input  logic [CORES*4-1:0]             req_cmd,
    input  logic [CORES*ADDR_W-1:0]        req_addr,
    output logic [CORES-1:0]               req_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [3:0]                     out_cmd,
    output logic [SRC_W-1:0]               out_src,
    output logic [ADDR_W-1:0]              out_addr,
    input  logic                           done_valid,
    input  logic [ADDR_W-1:0]              done_addr,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err
);

    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - OFF;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [3:0]        cmd_a  [CORES];
    logic [ADDR_W-1:0] addr_a [CORES];

    logic [SRC_W-1:0]     rr_q;
    logic [MAX_OUTST-1:0] vld_q;
    logic [TAG_W-1:0]     tag_q [MAX_OUTST];
    logic [CNT_W-1:0]     cnt_q;

    logic [CORES-1:0]     hit;
    logic [CORES-1:0]     elig;
    logic [MAX_OUTST-1:0] free_oh;
    logic [MAX_OUTST-1:0] done_oh;
    logic [SRC_W-1:0]     gnt_idx;
    logic [3:0]           gnt_cmd;
    logic [ADDR_W-1:0]    gnt_addr;
    logic                 found;
    logic                 full;
    logic                 slot_free;
    logic                 grant;
    logic                 legal;
    logic                 alloc;
    logic                 done_hit;
    logic                 free;
    logic                 unused_off;

    for (genvar g = 0; g < CORES; g++) begin : g_split
        assign cmd_a[g]  = req_cmd[g*4 +: 4];
        assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Blocking decisions use table state from the start of the cycle only.
    always_comb begin : hit_c
        hit = '0;
        for (int i = 0; i < CORES; i++) begin
            for (int e = 0; e < MAX_OUTST; e++) begin
                if (vld_q[e] && tag_q[e] == addr_a[i][ADDR_W-1:OFF]) begin
                    hit[i] = 1'b1;
                end
            end
        end
    end

    assign full      = &vld_q;
    assign slot_free = !out_valid || out_ready;
    assign elig      = req_valid & ~hit & {CORES{!full}};

    always_comb begin : pick_c
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < CORES; k++) begin
            idx = (int'(rr_q) + k) % CORES;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = SRC_W'(idx);
            end
        end
    end

    assign grant     = found && slot_free;
    assign gnt_cmd   = cmd_a[gnt_idx];
    assign gnt_addr  = addr_a[gnt_idx];
    assign legal     = gnt_cmd[3:2] == 2'b00;
    assign alloc     = grant && legal;
    assign req_ready = grant ? (CORES'(1) << gnt_idx) : '0;

    always_comb begin : tbl_c
        logic got;
        got     = 1'b0;
        free_oh = '0;
        done_oh = '0;
        for (int e = 0; e < MAX_OUTST; e++) begin
            if (!vld_q[e] && !got) begin
                free_oh[e] = 1'b1;
                got        = 1'b1;
            end
            if (vld_q[e] && tag_q[e] == done_addr[ADDR_W-1:OFF]) begin
                done_oh[e] = 1'b1;
            end
        end
    end

    assign done_hit   = |done_oh;
    assign free       = done_valid && done_hit;
    assign outst_cnt  = cnt_q;
    assign unused_off = ^done_addr[OFF-1:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_q      <= '0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
            out_src   <= '0;
            out_addr  <= '0;
            vld_q     <= '0;
            cnt_q     <= '0;
            err       <= 1'b0;
            for (int e = 0; e < MAX_OUTST; e++) tag_q[e] <= '0;
        end else begin
            if (grant) begin
                rr_q <= (gnt_idx == SRC_W'(CORES - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (alloc) begin
                out_valid <= 1'b1;
                out_cmd   <= gnt_cmd;
                out_src   <= gnt_idx;
                out_addr  <= gnt_addr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            vld_q <= (vld_q & ~(free ? done_oh : '0)) | (alloc ? free_oh : '0);
            for (int e = 0; e < MAX_OUTST; e++) begin
                if (alloc && free_oh[e]) tag_q[e] <= gnt_addr[ADDR_W-1:OFF];
            end
            case ({alloc, free})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            // Illegal commands are swallowed; unmatched completions are ignored.
            if ((done_valid && !done_hit) || (grant && !legal)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coh_req_arbiter.sv
// Scoreboard bench for coh_req_arbiter: a MAX_OUTST=2 instance for most
// scenarios and a MAX_OUTST=4 instance for the round-robin fairness run.
module tb_coh_req_arbiter;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  src;
        logic [31:0] addr;
    } exp_t;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [3:0]   req_valid;
    logic [15:0]  req_cmd;
    logic [127:0] req_addr;
    logic         out_ready;
    logic         done_valid;
    logic [31:0]  done_addr;

    logic [3:0]  rdy2, rdy4;
    logic        ov2, ov4;
    logic [3:0]  cmd2, cmd4;
    logic [1:0]  src2, src4;
    logic [31:0] addr2, addr4;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;
    logic        err2, err4;

    exp_t q2[$];
    exp_t q4[$];
    exp_t e2, e4;
    bit   mon2_en, mon4_en;
    int   checks, errors;

    always #5 CLK = ~CLK;

    coh_req_arbiter #(.CORES(4), .ADDR_W(32), .LINE_BYTES(32), .MAX_OUTST(2)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_ready(rdy2), .out_valid(ov2), .out_ready(out_ready),
        .out_cmd(cmd2), .out_src(src2), .out_addr(addr2),
        .done_valid(done_valid), .done_addr(done_addr),
        .outst_cnt(cnt2), .err(err2)
    );

    coh_req_arbiter #(.CORES(4), .ADDR_W(32), .LINE_BYTES(32), .MAX_OUTST(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_ready(rdy4), .out_valid(ov4), .out_ready(out_ready),
        .out_cmd(cmd4), .out_src(src4), .out_addr(addr4),
        .done_valid(done_valid), .done_addr(done_addr),
        .outst_cnt(cnt4), .err(err4)
    );

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge CLK) begin
        #2;
        if (mon2_en && nRST) begin
            checks++;
            if (cnt2 > 2'd2) begin
                errors++;
                $display("FAIL cnt2_bound: outst_cnt=%0d limit 2", cnt2);
            end
        end
        if (mon2_en && nRST && ov2 && out_ready) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL out2_unexpected: got src=%0d addr=%h, none expected", src2, addr2);
            end else begin
                e2 = q2.pop_front();
                if ({cmd2, src2, addr2} !== e2) begin
                    errors++;
                    $display("FAIL out2_data: got cmd=%0d src=%0d addr=%h want cmd=%0d src=%0d addr=%h",
                             cmd2, src2, addr2, e2.cmd, e2.src, e2.addr);
                end
            end
        end
        if (mon4_en && nRST && ov4 && out_ready) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL out4_unexpected: got src=%0d addr=%h, none expected", src4, addr4);
            end else begin
                e4 = q4.pop_front();
                if ({cmd4, src4, addr4} !== e4) begin
                    errors++;
                    $display("FAIL out4_data: got cmd=%0d src=%0d addr=%h want cmd=%0d src=%0d addr=%h",
                             cmd4, src4, addr4, e4.cmd, e4.src, e4.addr);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] c, input logic [1:0] s, input logic [31:0] a);
        mk = {c, s, a};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] c, input logic [31:0] a);
        req_valid[i]       = v;
        req_cmd[i*4 +: 4]  = c;
        req_addr[i*32 +: 32] = a;
    endtask

    task automatic clr_all();
        req_valid  = '0;
        req_cmd    = '0;
        req_addr   = '0;
        done_valid = 1'b0;
        done_addr  = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clr_all();
        out_ready = 1'b1;
        mon2_en = 1'b1;
        mon4_en = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov2); end
        checks++;
        if ({cmd2, src2, addr2} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out_regs: got cmd=%0d src=%0d addr=%h want 0", cmd2, src2, addr2);
        end
        checks++;
        if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt2); end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err2); end
        nRST = 1'b1;
    endtask

    task automatic test_single();
        @(negedge CLK);
        set_req(2, 1'b1, 4'd1, 32'h0000_1040);
        #1;
        checks++;
        if (rdy2 !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", rdy2); end
        q2.push_back(mk(4'd1, 2'd2, 32'h0000_1040));
        @(negedge CLK);
        set_req(2, 1'b0, 4'd0, 32'h0);
        done_valid = 1'b1;
        done_addr  = 32'h0000_1040;
        checks++;
        if (ov2 !== 1'b1 || src2 !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got valid=%b src=%0d want 1/2", ov2, src2);
        end
        checks++;
        if (cnt2 !== 2'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt2); end
        @(negedge CLK);
        done_valid = 1'b0;
        checks++;
        if (cnt2 !== 2'd0 || ov2 !== 1'b0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got cnt=%0d valid=%b err=%b want 0/0/0", cnt2, ov2, err2);
        end
    endtask

    task automatic test_same_line();
        @(negedge CLK);
        set_req(0, 1'b1, 4'd0, 32'h100);
        #1;
        checks++;
        if (rdy2 !== 4'b0001) begin errors++; $display("FAIL line_first: got %b want 0001", rdy2); end
        q2.push_back(mk(4'd0, 2'd0, 32'h100));
        @(negedge CLK);
        set_req(0, 1'b0, 4'd0, 32'h0);
        set_req(1, 1'b1, 4'd1, 32'h11C);
        set_req(3, 1'b1, 4'd0, 32'h200);
        #1;
        checks++;
        if (rdy2 !== 4'b1000) begin errors++; $display("FAIL line_other: got %b want 1000", rdy2); end
        q2.push_back(mk(4'd0, 2'd3, 32'h200));
        @(negedge CLK);
        set_req(3, 1'b0, 4'd0, 32'h0);
        #1;
        checks++;
        if (rdy2 !== 4'b0000 || cnt2 !== 2'd2) begin
            errors++;
            $display("FAIL line_blocked: got ready=%b cnt=%0d want 0000/2", rdy2, cnt2);
        end
        @(negedge CLK);
        done_valid = 1'b1;
        done_addr  = 32'h100;
        #1;
        checks++;
        if (rdy2 !== 4'b0000) begin errors++; $display("FAIL line_same_cycle: got %b want 0000", rdy2); end
        @(negedge CLK);
        done_valid = 1'b0;
        #1;
        checks++;
        if (rdy2 !== 4'b0010 || cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL line_release: got ready=%b cnt=%0d want 0010/1", rdy2, cnt2);
        end
        q2.push_back(mk(4'd1, 2'd1, 32'h11C));
        @(negedge CLK);
        set_req(1, 1'b0, 4'd0, 32'h0);
        done_valid = 1'b1;
        done_addr  = 32'h200;
        @(negedge CLK);
        done_addr  = 32'h118;
        @(negedge CLK);
        done_valid = 1'b0;
        checks++;
        if (cnt2 !== 2'd0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL line_drain: got cnt=%0d err=%b want 0/0", cnt2, err2);
        end
    endtask

    task automatic test_full_backpressure();
        @(negedge CLK);
        out_ready = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'h300);
        set_req(1, 1'b1, 4'd0, 32'h340);
        set_req(2, 1'b1, 4'd1, 32'h380);
        #1;
        checks++;
        if (rdy2 !== 4'b0100) begin errors++; $display("FAIL full_grant: got %b want 0100", rdy2); end
        q2.push_back(mk(4'd1, 2'd2, 32'h380));
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            if (s == 0) set_req(2, 1'b0, 4'd0, 32'h0);
            #1;
            checks++;
            if ({ov2, cmd2, src2, addr2} !== {1'b1, 4'd1, 2'd2, 32'h380} || rdy2 !== 4'b0000) begin
                errors++;
                $display("FAIL stall_%0d: got valid=%b cmd=%0d src=%0d addr=%h ready=%b want 1/1/2/380/0000",
                         s, ov2, cmd2, src2, addr2, rdy2);
            end
        end
        @(negedge CLK);
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 4'b0001) begin errors++; $display("FAIL full_second: got %b want 0001", rdy2); end
        q2.push_back(mk(4'd0, 2'd0, 32'h300));
        @(negedge CLK);
        set_req(0, 1'b0, 4'd0, 32'h0);
        #1;
        checks++;
        if (rdy2 !== 4'b0000 || cnt2 !== 2'd2) begin
            errors++;
            $display("FAIL full_block: got ready=%b cnt=%0d want 0000/2", rdy2, cnt2);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (rdy2 !== 4'b0000 || ov2 !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: got ready=%b valid=%b want 0000/0", rdy2, ov2);
        end
        @(negedge CLK);
        done_valid = 1'b1;
        done_addr  = 32'h380;
        #1;
        checks++;
        if (rdy2 !== 4'b0000) begin errors++; $display("FAIL full_done_cycle: got %b want 0000", rdy2); end
        @(negedge CLK);
        done_valid = 1'b0;
        #1;
        checks++;
        if (rdy2 !== 4'b0010) begin errors++; $display("FAIL full_third: got %b want 0010", rdy2); end
        q2.push_back(mk(4'd0, 2'd1, 32'h340));
        @(negedge CLK);
        set_req(1, 1'b0, 4'd0, 32'h0);
        done_valid = 1'b1;
        done_addr  = 32'h300;
        @(negedge CLK);
        done_addr  = 32'h340;
        @(negedge CLK);
        done_valid = 1'b0;
        checks++;
        if (cnt2 !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", cnt2); end
    endtask

    task automatic test_errors();
        @(negedge CLK);
        set_req(0, 1'b1, 4'd0, 32'h500);
        #1;
        checks++;
        if (rdy2 !== 4'b0001) begin errors++; $display("FAIL err_setup: got %b want 0001", rdy2); end
        q2.push_back(mk(4'd0, 2'd0, 32'h500));
        @(negedge CLK);
        set_req(0, 1'b0, 4'd0, 32'h0);
        done_valid = 1'b1;
        done_addr  = 32'h900;
        @(negedge CLK);
        done_valid = 1'b0;
        #1;
        checks++;
        if (err2 !== 1'b1 || cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL err_done: got err=%b cnt=%0d want 1/1", err2, cnt2);
        end
        set_req(1, 1'b1, 4'd4, 32'h600);
        #1;
        checks++;
        if (rdy2 !== 4'b0010) begin errors++; $display("FAIL err_cmd_accept: got %b want 0010", rdy2); end
        @(negedge CLK);
        set_req(1, 1'b1, 4'd0, 32'h640);
        set_req(2, 1'b1, 4'd1, 32'h680);
        #1;
        checks++;
        if (ov2 !== 1'b0 || err2 !== 1'b1 || cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL err_cmd_drop: got valid=%b err=%b cnt=%0d want 0/1/1", ov2, err2, cnt2);
        end
        checks++;
        if (rdy2 !== 4'b0100) begin errors++; $display("FAIL err_rr_adv: got %b want 0100", rdy2); end
        q2.push_back(mk(4'd1, 2'd2, 32'h680));
        @(negedge CLK);
        set_req(1, 1'b0, 4'd0, 32'h0);
        set_req(2, 1'b0, 4'd0, 32'h0);
        out_ready = 1'b0;
        #1;
        checks++;
        if (ov2 !== 1'b1 || cnt2 !== 2'd2) begin
            errors++;
            $display("FAIL err_state: got valid=%b cnt=%0d want 1/2", ov2, cnt2);
        end
    endtask

    task automatic test_async_reset();
        #3;
        nRST = 1'b0;
        q2.delete();
        #1;
        checks++;
        if (ov2 !== 1'b0 || cnt2 !== 2'd0 || err2 !== 1'b0 || addr2 !== 32'h0) begin
            errors++;
            $display("FAIL areset: got valid=%b cnt=%0d err=%b addr=%h want 0/0/0/0",
                     ov2, cnt2, err2, addr2);
        end
        @(negedge CLK);
        nRST = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, 32'hA00 + 32'(i) * 32'h40);
        #1;
        checks++;
        if (rdy2 !== 4'b0001) begin errors++; $display("FAIL areset_rr: got %b want 0001", rdy2); end
        q2.push_back(mk(4'd0, 2'd0, 32'hA00));
        @(negedge CLK);
        req_valid = '0;
        checks++;
        if (ov2 !== 1'b1 || src2 !== 2'd0) begin
            errors++;
            $display("FAIL areset_out: got valid=%b src=%0d want 1/0", ov2, src2);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] cmd;
        @(negedge CLK);
        mon2_en = 1'b0;
        mon4_en = 1'b1;
        nRST = 1'b0;
        clr_all();
        out_ready = 1'b1;
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i % 3), 32'h2000 + 32'(i) * 32'h40);
            done_valid = (c >= 2);
            done_addr  = 32'h2004 + 32'((c + 2) % 4) * 32'h40;
            #1;
            checks++;
            if (rdy4 !== 4'(1 << (c % 4))) begin
                errors++;
                $display("FAIL fair_c%0d: got ready=%b want %b", c, rdy4, 4'(1 << (c % 4)));
            end
            cmd = 4'((c % 4) % 3);
            q4.push_back(mk(cmd, 2'(c % 4), 32'h2000 + 32'(c % 4) * 32'h40));
        end
        @(negedge CLK);
        req_valid  = '0;
        done_addr  = 32'h2080;
        @(negedge CLK);
        done_addr  = 32'h20C0;
        @(negedge CLK);
        done_valid = 1'b0;
        checks++;
        if (cnt4 !== 3'd0 || ov4 !== 1'b0 || err4 !== 1'b0) begin
            errors++;
            $display("FAIL fair_drain: got cnt=%0d valid=%b err=%b want 0/0/0", cnt4, ov4, err4);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_same_line();
        test_full_backpressure();
        test_errors();
        test_async_reset();
        test_fairness();
        @(negedge CLK);
        checks++;
        if (q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d/%0d pending want 0/0", q2.size(), q4.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coh_req_arbiter.md
Name: coh_req_arbiter

Overview:
- Parametrised request arbiter for the coherence fabric, sitting between the per-core cache controllers and the bus/directory controller.
- Accepts coh_req_t-style requests (cmd, src, addr) from CORES request channels and grants them round-robin onto one output channel.
- Serialises requests to the same cache line: a line with a transaction already in flight is blocked until the downstream controller signals completion.
- Generalised in core count, line size and outstanding-transaction depth.

Parameters:
CORES, 4, number of request channels; must be >= 2
ADDR_W, 32, address width
LINE_BYTES, 32, line size in bytes (power of 2); line tag = addr[ADDR_W-1:log2(LINE_BYTES)]
MAX_OUTST, 2, in-flight transaction table depth (>= 1)
SRC_W, $clog2(CORES), source id width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
req_valid  in  CORES  per-core request valid
req_cmd  in  CORES*4  per-core command; GETS=0, GETM=1, UPG=2, PUTM=3
req_addr  in  CORES*ADDR_W  per-core byte address
req_ready  out  CORES  per-core accept; combinational, one-hot or zero
out_valid  out  1  granted request valid (registered)
out_ready  in  1  downstream accept
out_cmd  out  4  granted command
out_src  out  SRC_W  granted core index
out_addr  out  ADDR_W  granted address, passed through unmodified
done_valid  in  1  downstream completion of one transaction
done_addr  in  ADDR_W  address of the completed transaction (line tag compared)
outst_cnt  out  $clog2(MAX_OUTST+1)  valid table entries
err  out  1  sticky protocol-error flag

Behaviour:
- Reset, asynchronous on nRST low:
  - out_valid=0; out_cmd, out_src and out_addr = 0.
  - Table cleared; outst_cnt=0; err=0.
  - RR pointer=0.
  - Reset mid-transaction discards all in-flight state; no replay.
- Channel i is eligible when all of the following hold:
  - req_valid[i] = 1;
  - its line tag does not match any valid table entry;
  - no lower-RR-priority channel with the same tag is granted this cycle (only one grant per cycle, so this holds automatically);
  - the table is not full.
- Slot free: out_valid=0, or (out_valid && out_ready).
- Grant: when the slot is free and at least one channel is eligible, pick the first eligible channel searching from the RR pointer upward with wrap (CORES-1 -> 0).
  - req_ready of that channel = 1 in that cycle.
  - Next edge: output register loads cmd/src/addr and out_valid=1.
  - A table entry is allocated with the line tag.
  - RR pointer = grantee+1 mod CORES.
- No grant: the RR pointer holds.
- Output register holds stable while out_valid && !out_ready. out_valid drops the edge after acceptance unless a new grant loads it.
- Latency: request to out_valid is 1 cycle; back-to-back grants are possible every cycle while out_ready=1.
- Table occupancy: the entry stays valid after out handshake until done_valid with a matching tag.
- Completion: done_valid frees the matching entry at the clock edge.
- Eligibility uses the table state at the start of the cycle:
  - same-cycle done + same-line request -> not granted until next cycle;
  - full table + done same cycle -> no grant that cycle.
- done_valid with no matching tag: ignored, err<=1.
- Illegal req_cmd (>=4) on a granted channel: the request is still accepted (req_ready=1) but dropped. No output, no table entry, err<=1, RR pointer advances.
- Tags are unique by construction, so at most one entry matches a tag.
- outst_cnt is exact every cycle; simultaneous alloc and free leaves it unchanged.

Test Plan:
- Single request: core 2, GETM 0x0000_1040, out_ready=1 -> req_ready=4'b0100 cycle 0; out_valid cycle 1 with src=2, cmd=1, addr=0x0000_1040; outst_cnt=1.
- Fairness: all four cores request distinct lines continuously with MAX_OUTST=4 and done returned each cycle after out handshake -> grant order 0,1,2,3,0,1…; no core waits more than 3 grants.
- Same-line block:
  - Stimulus: core 0 GETS 0x100, then core 1 GETM 0x11C (same 32-byte line).
  - Required: core 1 is not granted until the cycle after done_valid with done_addr=0x100.
  - Core 3 GETS 0x200 is meanwhile granted.
- Table full and backpressure, MAX_OUTST=2:
  - Two grants are outstanding, a third core is pending, and out_ready=0 while a grant is held.
  - Required: out_* stays stable across 5 stall cycles; the third core gets no grant until a done arrives; outst_cnt never exceeds 2.
- Errors:
  - done_addr=0x900 matching no entry -> err=1, table unchanged.
  - Core 1 cmd=4 -> accepted, no out_valid, err stays 1.
- Async reset mid-op: assert nRST low between edges with out_valid=1 and 2 entries -> out_valid=0, outst_cnt=0, err=0 immediately; the first grant after release starts at core 0.
